branch_resolve_sequencer: RTL and testbench
===========================================

// Module: branch_resolve_sequencer
// PURPOSE
//   Multi-cycle controller that sequences one branch/jump at a time through the shared ALU.
//   Accepts a decoded branch request (op, pc, base, offset) and waits for the ALU compare result when needed.
//   Issues a single PC redirect (target or pc+4) to fetch, plus a pipeline flush pulse on a taken redirect.
//   Sits between the decode/branch-select stage and the fetch PC register.
// PARAMETERS
//   XLEN         32  datapath width of pc/base/offset/redirect
//   CMP_TIMEOUT  15  max cycles in WAIT_CMP before forced not-taken resolve (1..255)
//   CNT_W        16  width of taken_count statistics counter
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   req_valid    in   1      branch request valid
//   req_ready    out  1      block can accept request (state IDLE)
//   req_op       in   2      00 NEVER, 01 ALU_NON_ZERO, 10 ALU_ZERO, 11 ALWAYS
//   req_pc       in   XLEN   pc of the branch instruction
//   req_base     in   XLEN   target base operand (pc or rs1)
//   req_offset   in   XLEN   target offset (sign-extended imm)
//   cmp_valid    in   1      ALU compare result valid
//   cmp_zero     in   1      ALU result == 0
//   redir_valid  out  1      redirect presented to fetch
//   redir_ready  in   1      fetch accepts redirect
//   redir_pc     out  XLEN   next pc
//   redir_taken  out  1      redirect is a taken branch/jump
//   redir_misal  out  1      taken target not 4-byte aligned (target[1]==1)
//   redir_tmo    out  1      resolve forced by compare timeout
//   flush        out  1      1-cycle pulse: younger instructions must be squashed
//   busy         out  1      state != IDLE
//   taken_count  out  CNT_W  saturating count of accepted taken redirects
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; all outputs 0 except req_ready=1; taken_count=0; timer=0.
//   States: IDLE, WAIT_CMP, OUT.
//   IDLE: req_ready=1. On req_valid, latch op/pc/base/offset.
//     op 00 -> OUT, taken=0. op 11 -> OUT, taken=1. op 01/10 -> WAIT_CMP, timer=0.
//   WAIT_CMP: cmp_valid is sampled only here; cmp in the accept cycle is ignored.
//     cmp_valid -> OUT; taken = op10 ? cmp_zero : ~cmp_zero.
//     else timer++; if timer reaches CMP_TIMEOUT-1 without cmp_valid -> OUT, taken=0, tmo=1.
//     cmp_valid in the last timeout cycle wins (no timeout).
//   OUT: redir_* are registered on entry and held stable while redir_valid=1 && !redir_ready.
//     On redir_valid && redir_ready -> IDLE in the same edge.
//     flush = redir_taken for exactly that cycle.
//     If taken, taken_count++ saturating at all-ones.
//   Redirect PC:
//     target = (base + offset) mod 2^XLEN, with bit0 forced to 0.
//     not-taken pc = (pc + 4) mod 2^XLEN.
//     misal = taken & target[1]; a misaligned redirect is still issued unchanged.
//   Latency: op 00/11: redir_valid high the cycle after accept.
//     op 01/10: redir_valid high the cycle after the cmp_valid sample.
//   No new request is accepted before the redirect handshake completes.
//   req_ready stays 0 in the handshake cycle (IDLE is reached next cycle).
//   redir_valid never drops before redir_ready.
//   tmo and misal are only meaningful while redir_valid=1, and are 0 otherwise.
// TESTING
//   T1 op11 pc=0x100 base=0x100 off=0x40, ready=1
//      -> next cycle: redir_valid, pc=0x140, taken=1, flush pulse 1 cycle, count=1.
//   T2 op10 (BEQ) pc=0x200 base=0x200 off=-8, cmp_valid+zero=1 after 3 cycles
//      -> redir_pc=0x1F8, taken=1. Repeat with zero=0 -> 0x204, flush=0.
//   T3 op01, cmp_valid never asserted
//      -> after CMP_TIMEOUT cycles: redir pc+4, tmo=1, taken=0, count unchanged.
//   T4 op11 base=0x1001 off=0x2; redir_ready low 5 cycles
//      -> redir_pc=0x1002, misal=1; outputs stable 5 cycles; req_ready=0 throughout.
//   T5 pc=0xFFFFFFFC op00 -> redir_pc=0x0.
//      taken_count preloaded near max via 2^CNT_W taken -> holds 0xFFFF.
//   T6 reset asserted mid-WAIT_CMP and mid-OUT
//      -> immediately IDLE, redir_valid=0, flush=0, count=0; next request proceeds normally.

Source files
------------

// File: rtl/branch_resolve_sequencer.sv
// branch_resolve_sequencer: resolves one branch/jump at a time and issues a single PC redirect to fetch.
//   Ports: clk/reset (async, active-high).
//   Request side: req_valid/req_ready, req_op, req_pc, req_base, req_offset.
//   ALU compare: cmp_valid/cmp_zero.
//   Redirect side: redir_valid/redir_ready, redir_pc, redir_taken, redir_misal, redir_tmo.
//   Status: flush, busy, taken_count.
module branch_resolve_sequencer #(
  parameter int XLEN        = 32,
  parameter int CMP_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_base,
  input  logic [XLEN-1:0]  req_offset,
  input  logic             cmp_valid,
  input  logic             cmp_zero,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             redir_taken,
  output logic             redir_misal,
  output logic             redir_tmo,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;
  localparam logic [7:0] TMO_LAST = 8'(CMP_TIMEOUT - 1);
  state_t            r_state, w_next;
  logic              r_beq;
  logic [XLEN-1:0]   r_tgt, r_seq, r_pc;
  logic [7:0]        r_timer;
  logic              r_taken, r_misal, r_tmo;
  logic [CNT_W-1:0]  r_count;
  logic              w_idle, w_hs, w_load, w_taken, w_tmo;
  logic [XLEN-1:0]   w_tgt, w_seq;
  assign w_idle      = r_state == S_IDLE;
  // In IDLE the redirect candidates come straight from the request so op 00/11 resolve without waiting.
  assign w_tgt       = w_idle ? (req_base + req_offset) & {{(XLEN-1){1'b1}}, 1'b0} : r_tgt;
  assign w_seq       = w_idle ? req_pc + XLEN'(4) : r_seq;
  assign w_hs        = redir_valid & redir_ready;
  assign req_ready   = w_idle;
  assign busy        = ~w_idle;
  assign redir_valid = r_state == S_OUT;
  assign redir_pc    = r_pc;
  assign redir_taken = r_taken;
  assign redir_misal = r_misal;
  assign redir_tmo   = r_tmo;
  assign flush       = w_hs & r_taken;
  assign taken_count = r_count;
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_taken = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) begin
        w_next  = ^req_op ? S_WAIT : S_OUT;
        w_load  = ~^req_op;
        w_taken = &req_op;
      end
      // A compare arriving in the final timeout cycle still resolves normally.
      S_WAIT: if (cmp_valid || r_timer == TMO_LAST) begin
        w_next  = S_OUT;
        w_load  = 1'b1;
        w_taken = cmp_valid & (r_beq ? cmp_zero : ~cmp_zero);
        w_tmo   = ~cmp_valid;
      end
      S_OUT: if (redir_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_beq   <= 1'b0;
      r_tgt   <= '0;
      r_seq   <= '0;
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_misal <= 1'b0;
      r_tmo   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= r_state == S_WAIT ? r_timer + 8'd1 : '0;
      if (w_idle && req_valid) begin
        r_beq <= req_op[1];
        r_tgt <= w_tgt;
        r_seq <= w_seq;
      end
      // Redirect fields are cleared after the handshake so tmo/misal read 0 outside a valid redirect.
      if (w_load) begin
        r_pc    <= w_taken ? w_tgt : w_seq;
        r_taken <= w_taken;
        r_misal <= w_taken & w_tgt[1];
        r_tmo   <= w_tmo;
      end else if (w_hs) begin
        r_pc    <= '0;
        r_taken <= 1'b0;
        r_misal <= 1'b0;
        r_tmo   <= 1'b0;
      end
      if (w_hs && r_taken && !(&r_count)) r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_sequencer.sv
// tb_branch_resolve_sequencer: scoreboard bench for branch_resolve_sequencer.
module tb_branch_resolve_sequencer;
  localparam int TMO = 15;
  localparam int CW  = 4;
  logic          clk = 1'b0, reset = 1'b1;
  logic          req_valid = 1'b0, cmp_valid = 1'b0, cmp_zero = 1'b0, redir_ready = 1'b0;
  logic [1:0]    req_op = '0;
  logic [31:0]   req_pc = '0, req_base = '0, req_offset = '0;
  logic          req_ready, redir_valid, redir_taken, redir_misal, redir_tmo, flush, busy;
  logic [31:0]   redir_pc;
  logic [CW-1:0] taken_count;
  logic [CW-1:0] m_count = '0;
  int            n_tests = 0, n_fail = 0;
  typedef struct {logic [31:0] pc; logic taken; logic misal; logic tmo;} exp_t;
  exp_t q[$];

  branch_resolve_sequencer #(.XLEN(32), .CMP_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pc(req_pc), .req_base(req_base), .req_offset(req_offset), .cmp_valid(cmp_valid),
    .cmp_zero(cmp_zero), .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .redir_taken(redir_taken), .redir_misal(redir_misal), .redir_tmo(redir_tmo), .flush(flush),
    .busy(busy), .taken_count(taken_count));

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] base, input logic [31:0] off,
                              input logic tk, input logic tm);
    exp_t e;
    logic [31:0] t;
    t = (base + off) & 32'hFFFF_FFFE;
    e.pc = tk ? t : pc + 32'd4;
    e.taken = tk;
    e.misal = tk & t[1];
    e.tmo = tm;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && redir_valid && redir_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect got pc=%h, no redirect expected", redir_pc);
      end else begin
        e = q.pop_front();
        if ({redir_pc, redir_taken, redir_misal, redir_tmo, flush} !== {e.pc, e.taken, e.misal, e.tmo, e.taken}) begin
          n_fail++;
          $display("FAIL redirect got pc=%h t=%b m=%b tmo=%b fl=%b expected pc=%h t=%b m=%b tmo=%b fl=%b",
                   redir_pc, redir_taken, redir_misal, redir_tmo, flush, e.pc, e.taken, e.misal, e.tmo, e.taken);
        end
        if (e.taken && m_count != '1) m_count++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] base, input logic [31:0] off);
    req_op = op; req_pc = pc; req_base = base; req_offset = off; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req_ready, busy, redir_valid, flush, redir_tmo, redir_misal, redir_taken} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_flags got %b expected 1000000",
               {req_ready, busy, redir_valid, flush, redir_tmo, redir_misal, redir_taken});
    end
    n_tests++;
    if ({taken_count, redir_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got count=%h pc=%h expected 0", taken_count, redir_pc);
    end
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_always;
    redir_ready = 1'b1;
    q.push_back(mk(32'h100, 32'h100, 32'h40, 1'b1, 1'b0));
    send(2'b11, 32'h100, 32'h100, 32'h40);
    @(negedge clk);
    n_tests++;
    if ({redir_valid, flush, req_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL always_latency got v/fl/rdy=%b expected 110", {redir_valid, flush, req_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({redir_valid, flush, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL always_after got v/fl/rdy=%b expected 001", {redir_valid, flush, req_ready});
    end
    n_tests++;
    if (taken_count !== m_count) begin
      n_fail++;
      $display("FAIL always_count got %0d expected %0d", taken_count, m_count);
    end
    tick;
  endtask

  task automatic test_compare;
    int ops[4] = '{2, 2, 1, 1};
    bit zs[4]  = '{1, 0, 0, 1};
    int ds[4]  = '{2, 2, 0, 1};
    logic [31:0] b;
    redir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 32'h200 + 32'(i / 2) * 32'h100;
      cmp_valid = 1'b1;
      cmp_zero = ~zs[i];
      send(2'(ops[i]), b, b, 32'hFFFF_FFF8);
      cmp_valid = 1'b0;
      for (int d = 0; d < ds[i]; d++) begin
        @(negedge clk);
        n_tests++;
        if (redir_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL cmp_wait%0d got redir_valid=%b expected 0", i, redir_valid);
        end
        tick;
      end
      cmp_valid = 1'b1;
      cmp_zero = zs[i];
      q.push_back(mk(b, b, 32'hFFFF_FFF8, ops[i] == 2 ? zs[i] : ~zs[i], 1'b0));
      tick;
      cmp_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (redir_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL cmp_latency%0d got redir_valid=%b expected 1", i, redir_valid);
      end
      tick;
    end
  endtask

  task automatic test_timeout;
    int k;
    redir_ready = 1'b0;
    cmp_valid = 1'b0;
    send(2'b01, 32'h400, 32'h400, 32'h80);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (redir_valid) begin
        k = i;
        break;
      end
    end
    n_tests++;
    if (k != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d cycles expected %0d", k, TMO + 1);
    end
    q.push_back(mk(32'h400, 32'h400, 32'h80, 1'b0, 1'b1));
    tick;
    redir_ready = 1'b1;
    @(negedge clk);
    tick;
    @(negedge clk);
    n_tests++;
    if (taken_count !== m_count) begin
      n_fail++;
      $display("FAIL timeout_count got %0d expected %0d", taken_count, m_count);
    end
    tick;
    send(2'b10, 32'h600, 32'h600, 32'h20);
    repeat (TMO - 1) tick;
    cmp_valid = 1'b1;
    cmp_zero = 1'b1;
    q.push_back(mk(32'h600, 32'h600, 32'h20, 1'b1, 1'b0));
    tick;
    cmp_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({redir_valid, redir_tmo} !== 2'b10) begin
      n_fail++;
      $display("FAIL last_cycle_cmp got v/tmo=%b expected 10", {redir_valid, redir_tmo});
    end
    tick;
  endtask

  task automatic test_stall;
    redir_ready = 1'b0;
    q.push_back(mk(32'h500, 32'h1001, 32'h2, 1'b1, 1'b0));
    send(2'b11, 32'h500, 32'h1001, 32'h2);
    req_op = 2'b00; req_pc = 32'h900; req_base = '0; req_offset = '0; req_valid = 1'b1;
    q.push_back(mk(32'h900, 32'h0, 32'h0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({redir_valid, redir_taken, redir_misal, req_ready, flush} !== 5'b11100 || redir_pc !== 32'h1002) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v/t/m/rdy/fl=%b pc=%h expected 11100 pc=00001002",
                 i, {redir_valid, redir_taken, redir_misal, req_ready, flush}, redir_pc);
      end
      tick;
    end
    redir_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({redir_valid, req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL handshake_ready got v/rdy=%b expected 10", {redir_valid, req_ready});
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_handshake got req_ready=%b expected 1", req_ready);
    end
    tick;
    req_valid = 1'b0;
    @(negedge clk);
    tick;
  endtask

  task automatic test_wrap_sat;
    redir_ready = 1'b1;
    q.push_back(mk(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0));
    send(2'b00, 32'hFFFF_FFFC, 32'h0, 32'h0);
    @(negedge clk);
    tick;
    for (int i = 0; i < 20; i++) begin
      q.push_back(mk(32'h10 * i, 32'h2000, 32'(i) * 4, 1'b1, 1'b0));
      send(2'b11, 32'h10 * i, 32'h2000, 32'(i) * 4);
      @(negedge clk);
      tick;
    end
    @(negedge clk);
    n_tests++;
    if (taken_count !== m_count || taken_count !== {CW{1'b1}}) begin
      n_fail++;
      $display("FAIL count_saturate got %h expected %h (model %h)", taken_count, {CW{1'b1}}, m_count);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    redir_ready = 1'b1;
    send(2'b01, 32'h700, 32'h700, 32'h4);
    tick;
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, req_ready, redir_valid, flush} !== 4'b0100 || taken_count !== '0) begin
      n_fail++;
      $display("FAIL reset_in_wait got b/rdy/v/fl=%b count=%h expected 0100 count=0",
               {busy, req_ready, redir_valid, flush}, taken_count);
    end
    q.delete();
    m_count = '0;
    tick;
    reset = 1'b0;
    tick;
    redir_ready = 1'b0;
    send(2'b11, 32'h800, 32'h800, 32'h10);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({redir_valid, flush, redir_taken, busy, req_ready} !== 5'b00001 || taken_count !== '0) begin
      n_fail++;
      $display("FAIL reset_in_out got v/fl/t/b/rdy=%b count=%h expected 00001 count=0",
               {redir_valid, flush, redir_taken, busy, req_ready}, taken_count);
    end
    #1 reset = 1'b0;
    tick;
    redir_ready = 1'b1;
    q.push_back(mk(32'h900, 32'h900, 32'h8, 1'b1, 1'b0));
    send(2'b11, 32'h900, 32'h900, 32'h8);
    @(negedge clk);
    tick;
    @(negedge clk);
    n_tests++;
    if (taken_count !== m_count || taken_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL post_reset_count got %0d expected 1 (model %0d)", taken_count, m_count);
    end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_always;
    test_compare;
    test_timeout;
    test_stall;
    test_wrap_sat;
    test_reset_mid;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
